// File: rtl/ed_filter_pkg.sv
// Shared types, default parameters and output constants for the binarisation filter.
package ed_filter_pkg;

    localparam int unsigned DEF_WIDTH       = 320;
    localparam int unsigned DEF_HEIGHT      = 240;
    localparam int unsigned FRAME_PIXELS    = DEF_WIDTH * DEF_HEIGHT;
    localparam int unsigned DEF_LUMA_THRESH = 18;
    localparam int unsigned DEF_ROI_Y_START = 0;
    localparam int unsigned DEF_ROI_Y_END   = 239;
    localparam int unsigned DEF_RED_MIN     = 10;
    localparam int unsigned DEF_GB_MAX      = 5;
    localparam int unsigned DEF_STOP_THRESH = 2000;

    localparam logic [11:0] PIX_LINE = 12'hFFF;
    localparam logic [11:0] PIX_BG   = 12'h000;

    typedef enum logic [1:0] {StIdle, StProcess, StDivide, StDone} state_e;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pixel_t;

    function automatic logic [5:0] luma_sum(input pixel_t p);
        return 6'(p.r) + 6'(p.g) + 6'(p.b);
    endfunction

endpackage

// File: rtl/ed_seq_divider.sv
// 25-cycle restoring divider: 25-bit dividend by 17-bit divisor, floor quotient.
module ed_seq_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [24:0] i_dividend,
    input  logic [16:0] i_divisor,
    output logic        o_busy,
    output logic        o_done,
    output logic [24:0] o_quotient
);

    logic [24:0] r_q;
    logic [17:0] r_rem;
    logic [16:0] r_dvs;
    logic [4:0]  r_step;
    logic        r_busy;

    logic [24:0] w_q_src;
    logic [17:0] w_rem_src;
    logic [16:0] w_dvs;
    logic [17:0] w_rem_sh;
    logic [18:0] w_diff;
    logic [24:0] w_q_nxt;
    logic [17:0] w_rem_nxt;

    // The start cycle already performs the first step on the raw operands.
    always_comb begin
        w_q_src   = i_start ? i_dividend : r_q;
        w_rem_src = i_start ? 18'd0 : r_rem;
        w_dvs     = i_start ? i_divisor : r_dvs;
        w_rem_sh  = {w_rem_src[16:0], w_q_src[24]};
        w_diff    = {1'b0, w_rem_sh} - {2'b00, w_dvs};
        if (!w_diff[18]) begin
            w_rem_nxt = w_diff[17:0];
            w_q_nxt   = {w_q_src[23:0], 1'b1};
        end else begin
            w_rem_nxt = w_rem_sh;
            w_q_nxt   = {w_q_src[23:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q    <= '0;
            r_rem  <= '0;
            r_dvs  <= '0;
            r_step <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_q    <= w_q_nxt;
            r_rem  <= w_rem_nxt;
            r_dvs  <= i_divisor;
            r_step <= 5'd1;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_q    <= w_q_nxt;
            r_rem  <= w_rem_nxt;
            r_step <= r_step + 5'd1;
            if (r_step == 5'd24) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_busy && (r_step == 5'd24);
    assign o_quotient = w_q_nxt;

endmodule

// File: rtl/ed_binarisation_filter.sv
// Streams a frame, writes a binary line map, finds the line centroid and counts stop pixels.
// Define ED_EDGE_EN to output horizontal dark/light transitions instead of the plain map.
module ed_binarisation_filter
    import ed_filter_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned HEIGHT      = DEF_HEIGHT,
    parameter int unsigned LUMA_THRESH = DEF_LUMA_THRESH,
    parameter int unsigned ROI_Y_START = DEF_ROI_Y_START,
    parameter int unsigned ROI_Y_END   = DEF_ROI_Y_END,
    parameter int unsigned RED_MIN     = DEF_RED_MIN,
    parameter int unsigned GB_MAX      = DEF_GB_MAX,
    parameter int unsigned STOP_THRESH = DEF_STOP_THRESH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        waiting_for_new_frame,
    input  logic        enable,
    input  logic [11:0] data_in,
    output logic [16:0] read_addr,
    output logic        wr_enable,
    output logic [16:0] write_addr,
    output logic [11:0] data_out,
    output logic        frame_done,
    output logic [9:0]  h_centroid,
    output logic        stop_detect,
    output logic [17:0] stop_sum
);

    localparam logic [16:0] LastAddr   = 17'(WIDTH * HEIGHT - 1);
    localparam logic [9:0]  LastX      = 10'(WIDTH - 1);
    localparam logic [9:0]  CentreX    = 10'(WIDTH / 2);
    localparam logic [8:0]  RoiStart   = 9'(ROI_Y_START);
    localparam logic [8:0]  RoiSpan    = 9'(ROI_Y_END - ROI_Y_START);
    localparam logic [5:0]  LumaThresh = 6'(LUMA_THRESH);
    localparam logic [3:0]  RedMin     = 4'(RED_MIN);
    localparam logic [3:0]  GbMax      = 4'(GB_MAX);
    localparam logic [17:0] StopThresh = 18'(STOP_THRESH);

    state_e      r_state;
    logic [16:0] r_rd_addr;
    logic        r_issue_done;
    logic        r_valid;
    logic [16:0] r_wr_addr;
    logic [9:0]  r_x;
    logic [8:0]  r_y;
    logic [24:0] r_sum_x;
    logic [16:0] r_cnt;
    logic [17:0] r_stop_cnt;
    logic        r_frame_done;
    logic [9:0]  r_centroid;
    logic [17:0] r_stop_sum;
    logic        r_stop_detect;
`ifdef ED_EDGE_EN
    logic        r_prev_dark;
`endif

    pixel_t      w_pix;
    logic        w_dark;
    logic        w_stop;
    logic [8:0]  w_roi_off;
    logic        w_in_roi;
    logic        w_line;
    logic        w_div_start;
    logic        w_div_busy;
    logic        w_div_done;
    logic [24:0] w_quot;

    always_comb begin
        w_pix     = pixel_t'(data_in);
        w_dark    = luma_sum(w_pix) < LumaThresh;
        w_stop    = (w_pix.r >= RedMin) && (w_pix.g <= GbMax) && (w_pix.b <= GbMax);
        // Rows above the ROI wrap to a large offset, so one compare covers both bounds.
        w_roi_off = r_y - RoiStart;
        w_in_roi  = w_roi_off <= RoiSpan;
`ifdef ED_EDGE_EN
        w_line    = (r_x != 10'd0) && (w_dark != r_prev_dark);
`else
        w_line    = w_dark;
`endif
    end

    assign w_div_start = (r_state == StDivide) && !w_div_busy;

    ed_seq_divider u_div (
        .clk        (clk),
        .reset      (reset),
        .i_start    (w_div_start),
        .i_dividend (r_sum_x),
        .i_divisor  (r_cnt),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quotient (w_quot)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= StIdle;
            r_rd_addr     <= '0;
            r_issue_done  <= 1'b0;
            r_valid       <= 1'b0;
            r_wr_addr     <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_sum_x       <= '0;
            r_cnt         <= '0;
            r_stop_cnt    <= '0;
            r_frame_done  <= 1'b0;
            r_centroid    <= CentreX;
            r_stop_sum    <= '0;
            r_stop_detect <= 1'b0;
`ifdef ED_EDGE_EN
            r_prev_dark   <= 1'b0;
`endif
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    r_rd_addr <= '0;
                    r_valid   <= 1'b0;
                    if (enable && !waiting_for_new_frame) begin
                        r_state      <= StProcess;
                        r_issue_done <= 1'b0;
                        r_x          <= '0;
                        r_y          <= '0;
                        r_sum_x      <= '0;
                        r_cnt        <= '0;
                        r_stop_cnt   <= '0;
                    end
                end
                StProcess: begin
                    r_valid <= enable && !r_issue_done;
                    if (enable && !r_issue_done) begin
                        r_wr_addr <= r_rd_addr;
                        if (r_rd_addr == LastAddr) begin
                            r_issue_done <= 1'b1;
                        end else begin
                            r_rd_addr <= r_rd_addr + 17'd1;
                        end
                    end
                    if (r_valid) begin
                        if (w_dark && w_in_roi) begin
                            r_sum_x <= r_sum_x + {15'd0, r_x};
                            r_cnt   <= r_cnt + 17'd1;
                        end
                        if (w_stop) begin
                            r_stop_cnt <= r_stop_cnt + 18'd1;
                        end
                        if (r_x == LastX) begin
                            r_x <= '0;
                            r_y <= r_y + 9'd1;
                        end else begin
                            r_x <= r_x + 10'd1;
                        end
`ifdef ED_EDGE_EN
                        r_prev_dark <= w_dark;
`endif
                        if (r_wr_addr == LastAddr) begin
                            r_state <= StDivide;
                        end
                    end
                end
                StDivide: begin
                    if (w_div_done) begin
                        r_state       <= StDone;
                        r_frame_done  <= 1'b1;
                        r_stop_sum    <= r_stop_cnt;
                        r_stop_detect <= r_stop_cnt >= StopThresh;
                        if (r_cnt != 17'd0) begin
                            r_centroid <= (w_quot > 25'd1023) ? 10'h3FF : w_quot[9:0];
                        end
                    end
                end
                default: begin
                    r_state   <= StIdle;
                    r_rd_addr <= '0;
                end
            endcase
        end
    end

    assign read_addr   = r_rd_addr;
    assign wr_enable   = r_valid;
    assign write_addr  = r_wr_addr;
    assign data_out    = (r_valid && w_line) ? PIX_LINE : PIX_BG;
    assign frame_done  = r_frame_done;
    assign h_centroid  = r_centroid;
    assign stop_detect = r_stop_detect;
    assign stop_sum    = r_stop_sum;

endmodule

// File: tb/tb_ed_binarisation_filter.sv
// Self-checking bench for ed_binarisation_filter on a reduced 40x12 frame.
module tb_ed_binarisation_filter;

    localparam int W  = 40;
    localparam int H  = 12;
    localparam int N  = W * H;
    localparam int RS = 2;
    localparam int RE = 9;
    localparam int ST = 100;
    localparam int LT = 18;
    localparam int RM = 10;
    localparam int GM = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        waiting;
    logic        enable;
    logic [11:0] data_in;
    logic [16:0] read_addr;
    logic        wr_enable;
    logic [16:0] write_addr;
    logic [11:0] data_out;
    logic        frame_done;
    logic [9:0]  h_centroid;
    logic        stop_detect;
    logic [17:0] stop_sum;

    ed_binarisation_filter #(
        .WIDTH       (W),
        .HEIGHT      (H),
        .ROI_Y_START (RS),
        .ROI_Y_END   (RE),
        .STOP_THRESH (ST)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .waiting_for_new_frame (waiting),
        .enable                (enable),
        .data_in               (data_in),
        .read_addr             (read_addr),
        .wr_enable             (wr_enable),
        .write_addr            (write_addr),
        .data_out              (data_out),
        .frame_done            (frame_done),
        .h_centroid            (h_centroid),
        .stop_detect           (stop_detect),
        .stop_sum              (stop_sum)
    );

    always #5 clk = ~clk;

    // Synchronous frame-buffer RAM: data follows the address by one clock.
    logic [11:0] mem [N];
    always @(posedge clk) data_in <= (int'(read_addr) < N) ? mem[int'(read_addr)] : 12'h000;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model results.
    logic [11:0] exp_out [N];
    int exp_stop;
    int exp_cent = W / 2;

    // Captured frame observations.
    logic [11:0] obs [N];
    int obs_cnt, order_err, lat, tail_extra, tail_ra, tail_we;
    bit got_done;
    logic [9:0]  cap_cent;
    logic [17:0] cap_sum;
    logic        cap_det;

    function automatic logic [11:0] rand_pix();
        case ($urandom_range(0, 3))
            0: rand_pix = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                           4'($urandom_range(0, 7))};
            1: rand_pix = {4'($urandom_range(10, 15)), 4'($urandom_range(0, 6)),
                           4'($urandom_range(0, 6))};
            default: rand_pix = 12'($urandom);
        endcase
    endfunction

    // Expected outputs straight from the classification rules over the whole image.
    task automatic build_model();
        int sx, c, x, y, r, g, b;
        bit d, pd;
        sx = 0; c = 0; exp_stop = 0; pd = 1'b0;
        for (int a = 0; a < N; a++) begin
            x = a % W; y = a / W;
            r = int'(mem[a][11:8]); g = int'(mem[a][7:4]); b = int'(mem[a][3:0]);
            d = (r + g + b) < LT;
`ifdef ED_EDGE_EN
            exp_out[a] = (x != 0 && d != pd) ? 12'hFFF : 12'h000;
`else
            exp_out[a] = d ? 12'hFFF : 12'h000;
`endif
            pd = d;
            if (d && y >= RS && y <= RE) begin sx += x; c++; end
            if (r >= RM && g <= GM && b <= GM) exp_stop++;
        end
        if (c != 0) exp_cent = sx / c;
    endtask

    // mode 0: enable held high, 1: 10-cycle pause at pause_at, 2: random enable.
    task automatic run_frame(input int mode, input int pause_at, input bit keep_low);
        int cyc, next_wa, exp_ra;
        obs_cnt = 0; order_err = 0; lat = 0; got_done = 0; next_wa = 0;
        tail_extra = 0; tail_ra = 0; tail_we = 0;
        for (int a = 0; a < N; a++) obs[a] = 12'hxxx;
        waiting = 1'b0;
        enable  = 1'b1;
        cyc = 0;
        while (!got_done && cyc < 4 * N + 200) begin
            @(posedge clk); #1; cyc++;
            if (wr_enable) begin
                exp_ra = (next_wa == N - 1) ? N - 1 : next_wa + 1;
                if (int'(write_addr) != next_wa || int'(read_addr) != exp_ra) order_err++;
                if (int'(write_addr) < N) obs[int'(write_addr)] = data_out;
                next_wa++; obs_cnt++;
            end
            if (frame_done) begin
                got_done = 1; lat = cyc;
                cap_cent = h_centroid; cap_sum = stop_sum; cap_det = stop_detect;
            end
            if (cyc == 4 && !keep_low) waiting = 1'b1;
            case (mode)
                1: enable = !(cyc >= pause_at && cyc < pause_at + 10);
                2: enable = ($urandom_range(0, 3) != 0);
                default: enable = 1'b1;
            endcase
        end
        enable = 1'b1;
        n_cmp++;
        if (!got_done) begin
            n_err++;
            $display("FAIL frame_timeout: frame_done not seen after %0d cycles", cyc);
        end
        if (!keep_low) begin
            repeat (5) begin
                @(posedge clk); #1;
                if (frame_done) tail_extra++;
                if (wr_enable) tail_we++;
            end
            tail_ra = int'(read_addr);
        end
    endtask

    task automatic test_black();
        for (int a = 0; a < N; a++) mem[a] = 12'h000;
        build_model();
        run_frame(0, 0, 1'b0);
        for (int a = 0; a < N; a++) begin
            n_cmp++;
            if (obs[a] !== exp_out[a]) begin
                n_err++;
                if (n_err < 20) $display("FAIL black_pix[%0d]: got %h want %h", a, obs[a], exp_out[a]);
            end
        end
        n_cmp += 8;
        if (cap_cent !== 10'(exp_cent)) begin n_err++; $display("FAIL black_centroid: got %0d want %0d", cap_cent, exp_cent); end
        if (cap_sum !== 18'(exp_stop)) begin n_err++; $display("FAIL black_stop_sum: got %0d want %0d", cap_sum, exp_stop); end
        if (cap_det !== 1'b0) begin n_err++; $display("FAIL black_stop_detect: got %b want 0", cap_det); end
        if (lat != N + 27) begin n_err++; $display("FAIL black_latency: got %0d want %0d", lat, N + 27); end
        if (order_err != 0) begin n_err++; $display("FAIL black_addr_order: got %0d errors want 0", order_err); end
        if (obs_cnt != N) begin n_err++; $display("FAIL black_writes: got %0d want %0d", obs_cnt, N); end
        if (tail_extra != 0 || tail_we != 0) begin n_err++; $display("FAIL black_tail: done %0d we %0d want 0 0", tail_extra, tail_we); end
        if (tail_ra != 0) begin n_err++; $display("FAIL black_idle_read_addr: got %0d want 0", tail_ra); end
    endtask

    task automatic test_reset();
        for (int a = 0; a < N; a++) mem[a] = rand_pix();
        waiting = 1'b0; enable = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        n_cmp++;
        if (wr_enable !== 1'b1) begin n_err++; $display("FAIL reset_prerun_we: got %b want 1", wr_enable); end
        #3 reset = 1'b0;
        #1;
        exp_cent = W / 2;
        n_cmp += 8;
        if (read_addr !== 17'd0) begin n_err++; $display("FAIL reset_read_addr: got %0d want 0", read_addr); end
        if (wr_enable !== 1'b0) begin n_err++; $display("FAIL reset_wr_enable: got %b want 0", wr_enable); end
        if (write_addr !== 17'd0) begin n_err++; $display("FAIL reset_write_addr: got %0d want 0", write_addr); end
        if (data_out !== 12'h000) begin n_err++; $display("FAIL reset_data_out: got %h want 000", data_out); end
        if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        if (h_centroid !== 10'(W / 2)) begin n_err++; $display("FAIL reset_centroid: got %0d want %0d", h_centroid, W / 2); end
        if (stop_sum !== 18'd0) begin n_err++; $display("FAIL reset_stop_sum: got %0d want 0", stop_sum); end
        if (stop_detect !== 1'b0) begin n_err++; $display("FAIL reset_stop_detect: got %b want 0", stop_detect); end
        waiting = 1'b1;
        @(negedge clk) reset = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            n_cmp++;
            if (read_addr !== 17'd0 || wr_enable !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold_idle: read_addr %0d we %b want 0 0", read_addr, wr_enable);
            end
        end
    endtask

    // Shared body for frames whose result checks are the standard set.
    task automatic test_pattern_frame(input string name, input int mode, input int exp_lat);
        build_model();
        run_frame(mode, 100, 1'b0);
        for (int a = 0; a < N; a++) begin
            n_cmp++;
            if (obs[a] !== exp_out[a]) begin
                n_err++;
                if (n_err < 20) $display("FAIL %s_pix[%0d]: got %h want %h", name, a, obs[a], exp_out[a]);
            end
        end
        n_cmp += 5;
        if (cap_cent !== 10'(exp_cent)) begin n_err++; $display("FAIL %s_centroid: got %0d want %0d", name, cap_cent, exp_cent); end
        if (cap_sum !== 18'(exp_stop)) begin n_err++; $display("FAIL %s_stop_sum: got %0d want %0d", name, cap_sum, exp_stop); end
        if (cap_det !== (exp_stop >= ST)) begin n_err++; $display("FAIL %s_stop_detect: got %b want %b", name, cap_det, exp_stop >= ST); end
        if (order_err != 0 || obs_cnt != N) begin n_err++; $display("FAIL %s_writes: order errs %0d count %0d want 0 %0d", name, order_err, obs_cnt, N); end
        if (tail_extra != 0) begin n_err++; $display("FAIL %s_done_width: extra pulses %0d want 0", name, tail_extra); end
        if (exp_lat > 0) begin
            n_cmp++;
            if (lat != exp_lat) begin n_err++; $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat); end
        end
    endtask

    task automatic test_white();
        for (int a = 0; a < N; a++) mem[a] = 12'hFFF;
        test_pattern_frame("white", 0, N + 27);
        n_cmp++;
        if (cap_cent !== 10'(W / 2)) begin n_err++; $display("FAIL white_keeps_centroid: got %0d want %0d", cap_cent, W / 2); end
    endtask

    task automatic test_stripe();
        for (int a = 0; a < N; a++) mem[a] = (a % W >= 10 && a % W <= 14) ? 12'h000 : 12'hFFF;
        test_pattern_frame("stripe", 0, N + 27);
        n_cmp++;
        if (cap_cent !== 10'd12) begin n_err++; $display("FAIL stripe_centroid_abs: got %0d want 12", cap_cent); end
        test_pattern_frame("pause", 1, N + 37);
    endtask

    task automatic test_stop();
        for (int a = 0; a < N; a++) mem[a] = 12'hF00;
        test_pattern_frame("stop_all", 0, N + 27);
        n_cmp++;
        if (cap_sum !== 18'(N) || cap_det !== 1'b1) begin n_err++; $display("FAIL stop_all_abs: sum %0d det %b want %0d 1", cap_sum, cap_det, N); end
        for (int k = ST - 1; k <= ST; k++) begin
            for (int a = 0; a < N; a++) mem[a] = (a % 4 == 0 && a / 4 < k) ? 12'hF00 : 12'hFFF;
            test_pattern_frame("stop_thresh", 0, 0);
        end
    endtask

    task automatic test_roi();
        for (int a = 0; a < N; a++) mem[a] = 12'hFFF;
        mem[0 * W + 5] = 12'h000; mem[1 * W + 5] = 12'h000;
        mem[10 * W + 6] = 12'h000; mem[11 * W + 6] = 12'h000;
        mem[2 * W + 30] = 12'h000; mem[9 * W + 34] = 12'h000;
        test_pattern_frame("roi", 0, N + 27);
        n_cmp++;
        if (cap_cent !== 10'd32) begin n_err++; $display("FAIL roi_centroid_abs: got %0d want 32", cap_cent); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            for (int a = 0; a < N; a++) mem[a] = rand_pix();
            test_pattern_frame("random", 2, 0);
        end
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < N; a++) mem[a] = rand_pix();
        build_model();
        run_frame(0, 0, 1'b1);
        n_cmp += 2;
        if (cap_cent !== 10'(exp_cent) || cap_sum !== 18'(exp_stop)) begin
            n_err++;
            $display("FAIL b2b_first: cent %0d sum %0d want %0d %0d", cap_cent, cap_sum, exp_cent, exp_stop);
        end
        if (lat != N + 27) begin n_err++; $display("FAIL b2b_first_latency: got %0d want %0d", lat, N + 27); end
        for (int a = 0; a < N; a++) mem[a] = rand_pix();
        test_pattern_frame("b2b_second", 0, N + 28);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < N; a++) mem[a] = 12'h000;
        reset = 1'b0; waiting = 1'b1; enable = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        test_black();
        test_reset();
        test_white();
        test_stripe();
        test_stop();
        test_roi();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ed_binarisation_filter.md
Name: ed_binarisation_filter

Overview:
- Streams one 320x240 RGB444 frame from a synchronous frame-buffer RAM and classifies each pixel as line (dark) or background.
- Writes a binary image to an output buffer.
- Computes the horizontal centroid of line pixels and counts red "stop" pixels per frame.
- Sits between the camera frame buffer and the steering/stop control logic of the line follower.

Parameters:
- WIDTH, 320, pixels per row
- HEIGHT, 240, rows per frame
- LUMA_THRESH, 18, pixel is dark when R+G+B (4-bit nibbles, 6-bit sum) < LUMA_THRESH
- ROI_Y_START, 0, first row counted for the centroid
- ROI_Y_END, 239, last row counted for the centroid
- RED_MIN, 10, R >= RED_MIN for a stop pixel
- GB_MAX, 5, G <= GB_MAX and B <= GB_MAX for a stop pixel
- STOP_THRESH, 2000, stop_detect when stop_sum >= STOP_THRESH

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- waiting_for_new_frame  in  1  high holds block idle; a frame starts when low
- enable  in  1  high advances processing; low pauses
- data_in  in  12  {R[3:0],G[3:0],B[3:0]}, valid one clock after read_addr
- read_addr  out  17  source pixel address, row-major
- wr_enable  out  1  data_out/write_addr valid this cycle
- write_addr  out  17  destination pixel address
- data_out  out  12  FFF = line pixel, 000 = background
- frame_done  out  1  one-cycle pulse at end of frame results
- h_centroid  out  10  mean x of line pixels in ROI
- stop_detect  out  1  stop marker present in last frame
- stop_sum  out  18  stop-pixel count of last frame

Behaviour:
- Reset (async, active-low) values: all outputs 0 except h_centroid = WIDTH/2 (160). State = IDLE; accumulators cleared.
- FSM states: IDLE, PROCESS, DIVIDE, DONE.
- IDLE: read_addr = 0, wr_enable = 0. Move to PROCESS when enable=1 and waiting_for_new_frame=0; clear accumulators on entry.
- PROCESS, each cycle with enable=1: issue read_addr, then increment it. A valid flag is pipelined one cycle. When enable=0, read_addr holds and the returned data is discarded (valid=0).
- Valid pixel at address a, cycle after issue: wr_enable=1, write_addr=a, data_out per classification. Column/row counters x,y track a.
- Dark pixel with ROI_Y_START <= y <= ROI_Y_END: sum_x += x (25-bit), cnt += 1 (17-bit).
- Stop pixel (independent of dark test): stop counter += 1.
- After the pixel at address WIDTH*HEIGHT-1 is written, go to DIVIDE. The last address wraps nowhere: read_addr returns to 0 in IDLE.
- DIVIDE: restoring sequential divide sum_x/cnt, exactly 25 cycles; quotient truncated (floor). enable is ignored in DIVIDE/DONE.
- DONE, one cycle:
  - frame_done=1.
  - If cnt != 0, h_centroid = quotient; else h_centroid keeps its previous value.
  - stop_sum = stop counter; stop_detect = (counter >= STOP_THRESH).
  - Outputs held until the next DONE. Then go to IDLE.
- Back-to-back frames: if waiting_for_new_frame is still low, IDLE re-enters PROCESS on the next cycle.
- waiting_for_new_frame rising mid-frame has no effect; the frame completes.
- Arithmetic: all sums unsigned; widths sized so a full frame cannot overflow.

Optional Feature:
- Macro ED_EDGE_EN.
- Defined: data_out = FFF only where the current pixel's dark flag differs from the previous pixel's in the same row. At x=0, data_out = 000. Centroid and stop logic are unchanged.
- Undefined: data_out is the plain binary map.

Decomposition:
- Package ed_filter_pkg: state enum, pixel struct (r,g,b nibbles), FRAME_PIXELS = WIDTH*HEIGHT, FFF/000 output constants.
- One sub-module: ed_seq_divider (25-bit dividend, 17-bit divisor, start/done, 25-cycle restoring divider).

Test Plan:
- Reset asserted mid-frame -> all outputs 0, h_centroid 160 asynchronously. After release with waiting_for_new_frame=1 -> read_addr stays 0, wr_enable 0.
- Drop waiting_for_new_frame, data_in=000 constant:
  - read_addr 0,1,2…; write_addr trails by one cycle; data_out FFF.
  - frame_done pulses once; h_centroid=159; stop_sum=0; stop_detect=0.
- data_in=FFF constant -> data_out 000 everywhere, frame_done pulses, h_centroid remains 160.
- Black stripe at columns 100–109 on white -> h_centroid=104.
  - Same stimulus with enable low for 10 cycles mid-frame -> identical results, frame_done 10 cycles later.
- data_in=F00 everywhere -> stop_sum=76800, stop_detect=1, data_out FFF (sum 15 < 18).
- With ED_EDGE_EN, stripe frame -> data_out FFF only at x=100 and x=110 per row.
